// File: rtl/inst_fetch_cache.sv
// Direct-mapped read-only instruction cache, 32-byte lines refilled by a 4 x 64-bit burst.
// Optional hit/miss counters are compiled in with `define ICACHE_STATS_EN.
module inst_fetch_cache #(
  parameter int NUM_SETS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_read,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_resp,
  output logic        pmem_read,
  output logic [31:0] pmem_address,
  input  logic [63:0] pmem_rdata,
  input  logic        pmem_resp
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = 27 - IDX_W;

  // state | meaning
  // IDLE  | lookup; hits answer combinationally, a miss latches the line address
  // FILL  | burst read in progress, one beat stored per pmem_resp
  // WRITE | assembled line, tag and valid committed to the set
  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

  state_t               state, state_nxt;
  logic [NUM_SETS-1:0]  valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_SETS];
  logic [255:0]         data_q [NUM_SETS];
  logic [255:0]         line_buf;
  logic [26:0]          line_addr;
  logic [1:0]           beat_cnt;

  logic [IDX_W-1:0]     req_idx;
  logic [TAG_W-1:0]     req_tag;
  logic [2:0]           req_word;
  logic [IDX_W-1:0]     line_idx;
  logic [TAG_W-1:0]     line_tag;
  logic                 hit;
  logic                 miss;
  logic                 unused_addr_bits;

  assign req_idx          = inst_addr[4+IDX_W:5];
  assign req_tag          = inst_addr[31:5+IDX_W];
  assign req_word         = inst_addr[4:2];
  assign line_idx         = line_addr[IDX_W-1:0];
  assign line_tag         = line_addr[26:IDX_W];
  assign unused_addr_bits = ^inst_addr[1:0];
  assign pmem_address     = {line_addr, 5'b0};

  assign hit  = (state == IDLE) & inst_read & valid_q[req_idx] & (tag_q[req_idx] == req_tag);
  assign miss = (state == IDLE) & inst_read & ~hit;

  always_comb begin
    state_nxt  = state;
    pmem_read  = 1'b0;
    inst_resp  = 1'b0;
    inst_rdata = '0;
    case (state)
      IDLE: begin
        inst_resp = hit;
        if (hit) inst_rdata = data_q[req_idx][{req_word, 5'b0} +: 32];
        if (miss) state_nxt = FILL;
      end
      FILL: begin
        pmem_read = 1'b1;
        if (pmem_resp && (beat_cnt == 2'd3)) state_nxt = WRITE;
      end
      WRITE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      valid_q   <= '0;
      beat_cnt  <= 2'd0;
      line_addr <= '0;
    end else begin
      state <= state_nxt;
      if (miss) line_addr <= inst_addr[31:5];
      if ((state == FILL) && pmem_resp) beat_cnt <= beat_cnt + 2'd1;
      if (state == WRITE) valid_q[line_idx] <= 1'b1;
    end
  end

  // Line storage carries no reset: an entry is only observable once its valid bit is set.
  always_ff @(posedge clk) begin
    if ((state == FILL) && pmem_resp) line_buf[{beat_cnt, 6'b0} +: 64] <= pmem_rdata;
    if (state == WRITE) begin
      data_q[line_idx] <= line_buf;
      tag_q[line_idx]  <= line_tag;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit)  hit_count  <= hit_count + 32'd1;
      if (miss) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch_cache.sv
// Scoreboarded bench for inst_fetch_cache: directed scenarios then random fetches,
// against a line-level cache model and a randomly stalling burst memory.
module tb_inst_fetch_cache;
  localparam int NUM_SETS = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        inst_read = 1'b1;
  logic [31:0] inst_addr = '0;
  logic [31:0] inst_rdata;
  logic        inst_resp;
  logic        pmem_read;
  logic [31:0] pmem_address;
  logic [63:0] pmem_rdata = '0;
  logic        pmem_resp = 1'b0;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  always #5 clk = ~clk;

  inst_fetch_cache #(.NUM_SETS(NUM_SETS)) dut (
    .clk(clk), .reset(reset), .inst_read(inst_read), .inst_addr(inst_addr),
    .inst_rdata(inst_rdata), .inst_resp(inst_resp), .pmem_read(pmem_read),
    .pmem_address(pmem_address), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
`ifdef ICACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  typedef struct {logic [31:0] addr; bit exp_hit;} exp_t;

  int          checks = 0;
  int          failures = 0;
  exp_t        exp_q[$];
  logic [31:0] pmem_q[$];
  bit          m_valid[NUM_SETS];
  logic [31:0] m_line[NUM_SETS];
  int unsigned hit_total = 0;
  int unsigned miss_total = 0;
  int          mem_beats = 0;
  bit          in_burst = 0;
  bit          drove_beat = 0;
  int          wait_n = 0;
  bit          saw_pmem = 0;
  exp_t        mon_e;

  // Backing memory contents; line 0x40 holds words 0x0000_0000 .. 0x7777_7777.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {29'd0, a[4:2]};
    return (w * 32'h1111_1111) ^ ((a & 32'hFFFF_FFE0) ^ 32'h40);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a, input bit want_resp);
    logic [31:0] line;
    int          s;
    exp_t        e;
    line = a >> 5;
    s = int'(line % NUM_SETS);
    inst_addr = a;
    e.addr = a;
    e.exp_hit = m_valid[s] && (m_line[s] == line);
    if (!e.exp_hit) begin
      pmem_q.push_back(line << 5);
      m_valid[s] = 1'b1;
      m_line[s] = line;
      miss_total++;
    end
    if (want_resp) begin
      exp_q.push_back(e);
      hit_total++;
    end
  endtask

  task automatic wait_resp(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!inst_resp && n < 200);
    if (!inst_resp) begin
      checks++;
      failures++;
      $display("FAIL %s timeout actual=no_resp expected=resp", name);
    end
  endtask

  task automatic req(input logic [31:0] a, input string name);
    @(posedge clk);
    #1;
    issue(a, 1'b1);
    wait_resp(name);
  endtask

  task automatic wait_beats(input int k, input string name);
    int n;
    n = 0;
    while (mem_beats < k && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (mem_beats < k) begin
      checks++;
      failures++;
      $display("FAIL %s beat_timeout actual=%0d expected=%0d", name, mem_beats, k);
    end
  endtask

  // Monitor: pops the scoreboard on every inst_resp cycle.
  always @(negedge clk) begin
    if (!reset) begin
      wait_n = 0;
      saw_pmem = 0;
    end else if (inst_resp) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp actual=resp expected=none addr=%h", inst_addr);
      end else begin
        mon_e = exp_q.pop_front();
        check("rdata", inst_rdata, mem_word(mon_e.addr));
        if (mon_e.exp_hit) begin
          check("hit_latency", wait_n, 0);
          check("hit_no_pmem", saw_pmem, 0);
        end else begin
          check("miss_latency_ge6", wait_n >= 6, 1);
          check("miss_pmem_read", saw_pmem, 1);
        end
      end
      wait_n = 0;
      saw_pmem = 0;
    end else begin
      check("bubble_rdata", inst_rdata, 0);
      if (exp_q.size() != 0) begin
        wait_n++;
        if (pmem_read) saw_pmem = 1;
      end
    end
  end

  // Burst memory with random stalls and stray pmem_resp pulses outside a burst.
  always @(negedge clk) begin
    if (!reset) begin
      mem_beats = 0;
      in_burst = 0;
      drove_beat = 0;
      pmem_resp = 1'b0;
    end else begin
      if (drove_beat) mem_beats++;
      drove_beat = 0;
      if (pmem_read) begin
        if (!in_burst) begin
          in_burst = 1;
          if (pmem_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_burst actual=%h expected=none", pmem_address);
          end else begin
            check("pmem_address", pmem_address, pmem_q.pop_front());
          end
        end
        if (mem_beats >= 4) begin
          checks++;
          failures++;
          $display("FAIL pmem_read_after_4_beats actual=1 expected=0");
        end
        if (mem_beats < 4 && $urandom_range(0, 3) != 0) begin
          pmem_resp = 1'b1;
          pmem_rdata = {mem_word(pmem_address + 32'(8 * mem_beats + 4)),
                        mem_word(pmem_address + 32'(8 * mem_beats))};
          drove_beat = 1;
        end else begin
          pmem_resp = 1'b0;
          pmem_rdata = {$urandom, $urandom};
        end
      end else begin
        if (in_burst) check("beats_per_burst", mem_beats, 4);
        in_burst = 0;
        mem_beats = 0;
        pmem_resp = ($urandom_range(0, 5) == 0);
        pmem_rdata = {$urandom, $urandom};
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_inst_resp", inst_resp, 0);
    check("reset_pmem_read", pmem_read, 0);
    check("reset_pmem_address", pmem_address, 0);
    check("reset_inst_rdata", inst_rdata, 0);
    reset = 1'b1;
    issue(32'h0, 1'b1);
    wait_resp("read0_after_reset");

    req(32'h44, "cold_miss");
    for (int w = 0; w < 8; w++) req(32'h40 + 32'(4 * w), "hit_sweep");
    req(32'h144, "conflict_refill");
    req(32'h44, "conflict_remiss");

    req(32'h144, "evict_before_switch");
    @(posedge clk);
    #1;
    issue(32'h44, 1'b0);
    wait_beats(2, "switch_wait");
    issue(32'h84, 1'b1);
    wait_resp("midfill_switch_miss");
    req(32'h44, "after_switch_hit");

    req(32'h144, "evict_before_reset");
    @(posedge clk);
    #1;
    issue(32'h44, 1'b0);
    wait_beats(2, "reset_wait");
    #2;
    reset = 1'b0;
    #1;
    check("midfill_reset_inst_resp", inst_resp, 0);
    check("midfill_reset_pmem_read", pmem_read, 0);
    check("midfill_reset_pmem_address", pmem_address, 0);
`ifdef ICACHE_STATS_EN
    check("midfill_reset_hit_count", hit_count, 0);
    check("midfill_reset_miss_count", miss_count, 0);
`endif
    for (int s = 0; s < NUM_SETS; s++) m_valid[s] = 0;
    hit_total = 0;
    miss_total = 0;
    pmem_q.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    issue(32'h44, 1'b1);
    wait_resp("reset_midfill_remiss");

    @(posedge clk);
    #1;
    inst_read = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("read_low_no_resp", inst_resp, 0);
    end
    @(posedge clk);
    #1;
    inst_read = 1'b1;
    issue(32'h44, 1'b1);
    wait_resp("read_high_hit");

    for (int i = 0; i < 150; i++) req($urandom_range(0, 1023), "random");

    @(posedge clk);
    #1;
    inst_read = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("exp_q_drained", exp_q.size(), 0);
    check("pmem_q_drained", pmem_q.size(), 0);
`ifdef ICACHE_STATS_EN
    check("hit_count", hit_count, hit_total);
    check("miss_count", miss_count, miss_total);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
